// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: opcodes, the bubble word and the fetch FSM states.
package mips_pkg;

    localparam logic [5:0]  OP_LW    = 6'b100011;
    localparam logic [5:0]  OP_SW    = 6'b101011;
    localparam logic [5:0]  OP_BEQ   = 6'b000100;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_BR_WAIT  = 2'd2
    } fetch_state_e;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter with hold / word-aligned load / +4 increment; load wins over increment.
module fetch_pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    input  logic        load,
    input  logic [31:0] load_addr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    // Wraps naturally modulo 2^32.
    assign pc_plus4 = pc + 32'd4;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_addr & ~32'h0000_0003;
        end else if (inc) begin
            pc <= pc_plus4;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, load/store bubble insertion and branch wait,
// feeding a registered IF/ID pipeline register.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MEM_BUBBLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        id_stall,
    input  logic        br_resolved,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic [1:0]  fetch_state
);

    localparam logic [2:0] BUBBLES = 3'(MEM_BUBBLES);

    fetch_state_e state;
    logic [2:0]   bubble_cnt;
    logic [31:0]  pc;
    logic [31:0]  pc_plus4;
    logic         advance;
    logic         pc_inc;
    logic         pc_load;
    logic [5:0]   opcode;

    assign advance = ~id_stall;
    assign opcode  = imem_instr[31:26];
    assign pc_inc  = advance && (state == ST_RUN);
    assign pc_load = advance && (state == ST_BR_WAIT) && br_resolved && br_taken;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (pc_inc),
        .load      (pc_load),
        .load_addr (br_target),
        .pc        (pc),
        .pc_plus4  (pc_plus4)
    );

    assign imem_addr   = pc;
    assign fetch_state = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_RUN;
            bubble_cnt <= 3'd0;
            ifid_instr <= NOP_WORD;
            ifid_pc4   <= 32'h0;
            ifid_valid <= 1'b0;
        end else if (advance) begin
            case (state)
                ST_RUN: begin
                    ifid_instr <= imem_instr;
                    ifid_pc4   <= pc_plus4;
                    ifid_valid <= 1'b1;
                    if (is_mem_op(opcode) && (BUBBLES != 3'd0)) begin
                        state      <= ST_MEM_WAIT;
                        bubble_cnt <= BUBBLES;
                    end else if (opcode == OP_BEQ) begin
                        state <= ST_BR_WAIT;
                    end
                end
                ST_MEM_WAIT: begin
                    ifid_instr <= NOP_WORD;
                    ifid_valid <= 1'b0;
                    bubble_cnt <= bubble_cnt - 3'd1;
                    // <= 1 rather than == 1 so a zero count cannot wrap into a long stall.
                    if (bubble_cnt <= 3'd1) begin
                        state      <= ST_RUN;
                        bubble_cnt <= 3'd0;
                    end
                end
                ST_BR_WAIT: begin
                    ifid_instr <= NOP_WORD;
                    ifid_valid <= 1'b0;
                    if (br_resolved) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    state      <= ST_RUN;
                    bubble_cnt <= 3'd0;
                end
            endcase
        end
    end

endmodule
